set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache.sv | 202 ++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: read-only, set-associative cache between a processor bus
// and a memory bus. One request is in flight at a time. Misses fetch a full
// line from memory, then every request returns the whole line, word 0 first.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   p_bus_*             : processor side (request in, line-beat response out)
//   m_bus_*             : memory side (line-fill request out, fill beats in)
//   hit_count/miss_count: saturating lookup statistics
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for p_bus_reqcyc; acknowledges and latches request
// S_LOOKUP  | tag compare; hit -> S_RESPOND, miss -> pick victim, S_MEMREQ
// S_MEMREQ  | line-fill request held until m_bus_reqack
// S_REFILL  | accepting tag-matched fill beats into the victim way
// S_RESPOND | returning line words 0..LINE_BEATS-1 under p_bus_respack
module set_assoc_cache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int WAYS           = 2,
  parameter int SETS           = 64,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p_bus_reqcyc,
  output logic                      p_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
  output logic                      p_bus_respcyc,
  input  logic                      p_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int OFF_W  = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = BUS_DATA_WIDTH - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEMREQ, S_REFILL, S_RESPOND
  } state_t;

  state_t                    r_state;
  logic [LINE_W-1:0]         r_line;
  logic [BUS_TAG_WIDTH-1:0]  r_reqtag;
  logic [WAY_W-1:0]          r_way;
  logic [BEAT_W-1:0]         r_beat;
  logic [31:0]               r_hit_cnt;
  logic [31:0]               r_miss_cnt;

  logic [BUS_DATA_WIDTH-1:0] r_data  [WAYS][SETS][LINE_BEATS];
  logic [TAG_W-1:0]          r_tags  [WAYS][SETS];
  logic [WAYS-1:0]           r_valid [SETS];
  logic [WAY_W-1:0]          r_ptr   [SETS];

  logic [IDX_W-1:0]          w_index;
  logic [TAG_W-1:0]          w_tag;
  logic                      w_hit;
  logic [WAY_W-1:0]          w_hit_way;
  logic                      w_has_free;
  logic [WAY_W-1:0]          w_victim;
  logic                      w_fill_fire;
  logic [BUS_DATA_WIDTH-1:0] w_rd_word;
  logic                      w_unused;

  // Byte offset within the line is irrelevant: responses always start at word 0.
  assign w_unused = ^p_bus_req[OFF_W-1:0];

  assign w_index = r_line[IDX_W-1:0];
  assign w_tag   = r_line[LINE_W-1:IDX_W];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_index][w] && (r_tags[w][w_index] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way first; the round-robin pointer only matters when full.
  always_comb begin
    w_has_free = 1'b0;
    w_victim   = r_ptr[w_index];
    for (int w = 0; w < WAYS; w++) begin
      if (!w_has_free && !r_valid[w_index][w]) begin
        w_has_free = 1'b1;
        w_victim   = WAY_W'(w);
      end
    end
  end

  assign w_fill_fire = (r_state == S_REFILL) && m_bus_respcyc &&
                       (m_bus_resptag == r_reqtag);
  assign w_rd_word   = r_data[r_way][w_index][r_beat];

  // Outputs are gated by reset so the buses are quiet while reset is held.
  assign p_bus_reqack  = !reset && (r_state == S_IDLE) && p_bus_reqcyc;
  assign p_bus_respcyc = !reset && (r_state == S_RESPOND);
  assign p_bus_resp    = p_bus_respcyc ? w_rd_word : '0;
  assign p_bus_resptag = p_bus_respcyc ? r_reqtag : '0;
  assign m_bus_reqcyc  = !reset && (r_state == S_MEMREQ);
  assign m_bus_req     = m_bus_reqcyc ? {r_line, {OFF_W{1'b0}}} : '0;
  assign m_bus_reqtag  = m_bus_reqcyc ? r_reqtag : '0;
  assign m_bus_respack = !reset && w_fill_fire;
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_reqtag   <= '0;
      r_way      <= '0;
      r_beat     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (p_bus_reqcyc) begin
            r_line   <= p_bus_req[BUS_DATA_WIDTH-1:OFF_W];
            r_reqtag <= p_bus_reqtag;
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_beat <= '0;
          if (w_hit) begin
            r_way   <= w_hit_way;
            r_state <= S_RESPOND;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
          end else begin
            r_way <= w_victim;
            // Invalidate up front so an aborted fill never leaves stale data valid.
            r_valid[w_index][w_victim] <= 1'b0;
            if (!w_has_free)
              r_ptr[w_index] <= (r_ptr[w_index] == LAST_WAY) ? '0 : r_ptr[w_index] + 1'b1;
            r_state <= S_MEMREQ;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
          end
        end
        S_MEMREQ: begin
          if (m_bus_reqack) r_state <= S_REFILL;
        end
        S_REFILL: begin
          if (w_fill_fire) begin
            if (r_beat == LAST_BEAT) begin
              r_valid[w_index][r_way] <= 1'b1;
              r_beat  <= '0;
              r_state <= S_RESPOND;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_RESPOND: begin
          if (p_bus_respack) begin
            if (r_beat == LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_fill_fire) begin
      r_data[r_way][w_index][r_beat] <= m_bus_resp;
      if (r_beat == LAST_BEAT) r_tags[r_way][w_index] <= w_tag;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with default parameters
// (64-bit buses, 2 ways, 64 sets, 8-beat lines => 6 offset bits, 6 index bits).
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_bus_reqcyc = 1'b0;
  logic        p_bus_reqack;
  logic [63:0] p_bus_req = '0;
  logic [12:0] p_bus_reqtag = '0;
  logic        p_bus_respcyc;
  logic        p_bus_respack = 1'b0;
  logic [63:0] p_bus_resp;
  logic [12:0] p_bus_resptag;
  logic        m_bus_reqcyc;
  logic        m_bus_reqack = 1'b0;
  logic [63:0] m_bus_req;
  logic [12:0] m_bus_reqtag;
  logic        m_bus_respcyc = 1'b0;
  logic        m_bus_respack;
  logic [63:0] m_bus_resp = '0;
  logic [12:0] m_bus_resptag = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  set_assoc_cache dut (
    .clk(clk), .reset(reset),
    .p_bus_reqcyc(p_bus_reqcyc), .p_bus_reqack(p_bus_reqack),
    .p_bus_req(p_bus_req), .p_bus_reqtag(p_bus_reqtag),
    .p_bus_respcyc(p_bus_respcyc), .p_bus_respack(p_bus_respack),
    .p_bus_resp(p_bus_resp), .p_bus_resptag(p_bus_resptag),
    .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack),
    .m_bus_req(m_bus_req), .m_bus_reqtag(m_bus_reqtag),
    .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
    .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] fw(input logic [63:0] line_addr, input int k);
    return {line_addr[31:0], 24'hD0D0D0, 8'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_reqack"},  {63'd0, p_bus_reqack},  64'd0);
    check({name, "_respcyc"}, {63'd0, p_bus_respcyc}, 64'd0);
    check({name, "_resp"},    p_bus_resp,             64'd0);
    check({name, "_resptag"}, {51'd0, p_bus_resptag}, 64'd0);
    check({name, "_mreqcyc"}, {63'd0, m_bus_reqcyc},  64'd0);
    check({name, "_mreq"},    m_bus_req,              64'd0);
    check({name, "_mreqtag"}, {51'd0, m_bus_reqtag},  64'd0);
    check({name, "_mrespack"},{63'd0, m_bus_respack}, 64'd0);
  endtask

  task automatic issue(input logic [63:0] addr, input logic [12:0] tag);
    p_bus_req    = addr;
    p_bus_reqtag = tag;
    p_bus_reqcyc = 1'b1;
    #1;
    check("reqack", {63'd0, p_bus_reqack}, 64'd1);
    tick();
    p_bus_reqcyc = 1'b0;
  endtask

  task automatic mem_phase(input logic [63:0] addr, input logic [12:0] tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_bus_reqcyc) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("mreq_seen", {63'd0, seen}, 64'd1);
    check("mreq_addr", m_bus_req, addr & ~64'h3F);
    check("mreq_tag", {51'd0, m_bus_reqtag}, {51'd0, tag});
    m_bus_reqack = 1'b1;
    tick();
    m_bus_reqack = 1'b0;
    check("mreq_drop", {63'd0, m_bus_reqcyc}, 64'd0);
  endtask

  task automatic fill(input logic [63:0] addr, input logic [12:0] tag, input int bad_at, input int stop_at);
    for (int k = 0; k < 8; k++) begin
      if (k == stop_at) return;
      if (k == bad_at) begin
        m_bus_respcyc = 1'b1;
        m_bus_resptag = tag ^ 13'h1;
        m_bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("badtag_noack", {63'd0, m_bus_respack}, 64'd0);
        tick();
      end
      m_bus_respcyc = 1'b1;
      m_bus_resptag = tag;
      m_bus_resp    = fw(addr & ~64'h3F, k);
      #1;
      check("fill_ack", {63'd0, m_bus_respack}, 64'd1);
      tick();
    end
    m_bus_respcyc = 1'b0;
  endtask

  task automatic collect(input logic [63:0] line_addr, input logic [12:0] tag, input int stall_at);
    for (int j = 0; j < 8; j++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (p_bus_respcyc) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("resp_seen", {63'd0, seen}, 64'd1);
      check("resp_data", p_bus_resp, fw(line_addr, j));
      check("resp_tag", {51'd0, p_bus_resptag}, {51'd0, tag});
      if (j == stall_at) begin
        p_bus_respack = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_cyc", {63'd0, p_bus_respcyc}, 64'd1);
          check("stall_data", p_bus_resp, fw(line_addr, j));
        end
      end
      p_bus_respack = 1'b1;
      tick();
      p_bus_respack = 1'b0;
    end
    check("resp_done", {63'd0, p_bus_respcyc}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request pending: nothing may be acknowledged.
    p_bus_reqcyc = 1'b1;
    p_bus_req    = 64'h1000;
    p_bus_reqtag = 13'd3;
    tick();
    tick();
    check_quiet("rst");
    reset        = 1'b0;
    p_bus_reqcyc = 1'b0;
    tick();
    check("rst_hits", {32'd0, hit_count}, 64'd0);
    check("rst_miss", {32'd0, miss_count}, 64'd0);

    // Cold miss of 0x1000 (set 0, way 0).
    issue(64'h1000, 13'd5);
    mem_phase(64'h1000, 13'd5);
    fill(64'h1000, 13'd5, -1, 8);
    collect(64'h1000, 13'd5, -1);
    check("cold_miss", {32'd0, miss_count}, 64'd1);
    check("cold_hits", {32'd0, hit_count}, 64'd0);

    // Hit on 0x1008; request held into LOOKUP must not be re-acknowledged.
    p_bus_req    = 64'h1008;
    p_bus_reqtag = 13'd6;
    p_bus_reqcyc = 1'b1;
    #1;
    check("hit_reqack", {63'd0, p_bus_reqack}, 64'd1);
    tick();
    check("busy_noack", {63'd0, p_bus_reqack}, 64'd0);
    check("hit_lat1", {63'd0, p_bus_respcyc}, 64'd0);
    p_bus_reqcyc = 1'b0;
    tick();
    check("hit_lat2", {63'd0, p_bus_respcyc}, 64'd1);
    check("hit_nomreq", {63'd0, m_bus_reqcyc}, 64'd0);
    collect(64'h1000, 13'd6, -1);
    check("hit_hits", {32'd0, hit_count}, 64'd1);
    check("hit_miss", {32'd0, miss_count}, 64'd1);

    // 0x2000 fills way 1 of set 0; a wrong-tag beat is injected before beat 2.
    issue(64'h2000, 13'd7);
    mem_phase(64'h2000, 13'd7);
    fill(64'h2000, 13'd7, 2, 8);
    collect(64'h2000, 13'd7, -1);

    // 0x3000: set full, pointer 0 -> evicts 0x1000.
    issue(64'h3000, 13'd8);
    mem_phase(64'h3000, 13'd8);
    fill(64'h3000, 13'd8, -1, 8);
    collect(64'h3000, 13'd8, -1);
    check("evict_miss3", {32'd0, miss_count}, 64'd3);

    // 0x1000 again must miss; stall the response at beat 3.
    issue(64'h1000, 13'd9);
    mem_phase(64'h1000, 13'd9);
    fill(64'h1000, 13'd9, -1, 8);
    collect(64'h1000, 13'd9, 3);
    check("reread_miss", {32'd0, miss_count}, 64'd4);

    // 0x3000 survived the last eviction (pointer moved to way 1).
    issue(64'h3010, 13'd10);
    tick();
    check("hit2_cyc", {63'd0, p_bus_respcyc}, 64'd1);
    check("hit2_nomreq", {63'd0, m_bus_reqcyc}, 64'd0);
    collect(64'h3000, 13'd10, -1);
    check("hit2_hits", {32'd0, hit_count}, 64'd2);

    // Reset arriving with fill beat 4 on the bus.
    issue(64'h4040, 13'd11);
    mem_phase(64'h4040, 13'd11);
    fill(64'h4040, 13'd11, -1, 4);
    m_bus_respcyc = 1'b1;
    m_bus_resptag = 13'd11;
    m_bus_resp    = fw(64'h4040, 4);
    reset         = 1'b1;
    #1;
    check("rstfill_noack", {63'd0, m_bus_respack}, 64'd0);
    tick();
    check_quiet("rstfill");
    check("rstfill_hits", {32'd0, hit_count}, 64'd0);
    check("rstfill_miss", {32'd0, miss_count}, 64'd0);
    m_bus_respcyc = 1'b0;
    reset         = 1'b0;
    tick();
    check_quiet("postrst");

    issue(64'h4040, 13'd11);
    mem_phase(64'h4040, 13'd11);
    fill(64'h4040, 13'd11, -1, 8);
    collect(64'h4040, 13'd11, -1);
    check("post_miss", {32'd0, miss_count}, 64'd1);
    check("post_hits", {32'd0, hit_count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
